// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, instruction fields and fetch state enum
package cpu_pkg;

  localparam int WORD_SIZE = 16;
  localparam logic [15:0] BUBBLE_INST = 16'hF008;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] inst_opcode(input logic [15:0] inst);
    return inst[OPCODE_HI:OPCODE_LO];
  endfunction

  function automatic logic [5:0] inst_func(input logic [15:0] inst);
    return inst[FUNC_HI:FUNC_LO];
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module ifid_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [15:0] load_inst,
  input  logic [15:0] load_pc_next,
  output logic        valid,
  output logic [15:0] inst,
  output logic [15:0] pc_next
);

  // bubble wins over load; neither asserted means hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid   <= 1'b0;
      inst    <= BUBBLE_INST;
      pc_next <= 16'h0000;
    end else if (bubble) begin
      valid   <= 1'b0;
      inst    <= BUBBLE_INST;
      pc_next <= 16'h0000;
    end else if (load) begin
      valid   <= 1'b1;
      inst    <= load_inst;
      pc_next <= load_pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, instruction memory handshake and IF/ID (optional FETCH_COUNT_EN)
module fetch_unit #(
  parameter int          WORD_SIZE = 16,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 ifid_valid,
  output logic [WORD_SIZE-1:0] ifid_inst,
  output logic [WORD_SIZE-1:0] ifid_pc_next,
  output logic [3:0]           opcode,
`ifdef FETCH_COUNT_EN
  output logic [5:0]           func_code,
  output logic [15:0]          fetch_count
`else
  output logic [5:0]           func_code
`endif
);

  import cpu_pkg::*;

  fetch_state_t state, state_n;
  logic [15:0]  pc, pc_n, pc_plus1;
  logic [15:0]  saved_pc, saved_pc_n;
  logic [15:0]  skid, skid_n;
  logic         halt_wait, halt_wait_n;
  logic         ld, bub;
  logic [15:0]  ld_inst;

  assign pc_plus1  = pc + 16'd1;
  assign i_address = pc;
  // the address stays at pc while DROP/HALTED drain the old request
  assign i_readM   = reset_n & ((state == FETCH) | (state == DROP) |
                                ((state == HALTED) & halt_wait));

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    saved_pc_n  = saved_pc;
    skid_n      = skid;
    halt_wait_n = halt_wait;
    ld          = 1'b0;
    bub         = 1'b0;
    ld_inst     = i_data;
    case (state)
      FETCH: begin
        if (redirect) begin
          bub = 1'b1;
          if (i_ready) pc_n = redirect_pc;
          else begin
            saved_pc_n = redirect_pc;
            state_n    = DROP;
          end
        end else if (halt) begin
          bub         = 1'b1;
          state_n     = HALTED;
          halt_wait_n = ~i_ready;
        end else if (i_ready) begin
          if (!stall) begin
            ld   = 1'b1;
            pc_n = pc_plus1;
          end else begin
            skid_n  = i_data;
            state_n = HOLD;
          end
        end else if (!stall) begin
          bub = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          bub     = 1'b1;
          pc_n    = redirect_pc;
          state_n = FETCH;
        end else if (halt) begin
          bub         = 1'b1;
          state_n     = HALTED;
          halt_wait_n = 1'b0;
        end else if (!stall) begin
          ld      = 1'b1;
          ld_inst = skid;
          pc_n    = pc_plus1;
          state_n = FETCH;
        end
      end
      DROP: begin
        if (redirect) begin
          bub        = 1'b1;
          saved_pc_n = redirect_pc;
          if (i_ready) begin
            pc_n    = redirect_pc;
            state_n = FETCH;
          end
        end else if (halt) begin
          bub         = 1'b1;
          state_n     = HALTED;
          halt_wait_n = ~i_ready;
        end else begin
          bub = ~stall;
          if (i_ready) begin
            pc_n    = saved_pc;
            state_n = FETCH;
          end
        end
      end
      HALTED: begin
        bub         = 1'b1;
        halt_wait_n = halt_wait & ~i_ready;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      saved_pc  <= 16'h0000;
      skid      <= 16'h0000;
      halt_wait <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      saved_pc  <= saved_pc_n;
      skid      <= skid_n;
      halt_wait <= halt_wait_n;
    end
  end

  ifid_reg u_ifid_reg (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (ld),
    .bubble       (bub),
    .load_inst    (ld_inst),
    .load_pc_next (pc_plus1),
    .valid        (ifid_valid),
    .inst         (ifid_inst),
    .pc_next      (ifid_pc_next)
  );

  assign opcode    = inst_opcode(ifid_inst);
  assign func_code = inst_func(ifid_inst);

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) fetch_count <= 16'h0000;
    else if (ld)  fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined 16-bit CPU, directly upstream of the control unit. Owns the PC, runs the request/ready handshake with instruction memory, and holds the IF/ID register. It presents `opcode` and `func_code` from the IF/ID instruction straight to the control unit. It also handles stall, redirect (branch/jump flush) and halt.

## Interface
- `WORD_SIZE`, 16: instruction/PC width.
- `RESET_PC`, 16'h0000: PC value after reset.

- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `i_readM` out 1: instruction fetch request.
- `i_address` out WORD_SIZE: fetch address (word-addressed).
- `i_data` in WORD_SIZE: returned instruction, valid when `i_ready`.
- `i_ready` in 1: memory completes the current request this cycle.
- `stall` in 1: hazard unit holds the IF/ID register.
- `redirect` in 1: a taken branch or jump; flushes IF/ID.
- `redirect_pc` in WORD_SIZE: new PC, valid with `redirect`.
- `halt` in 1: decoded halt; stops all further fetching.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `ifid_inst` out WORD_SIZE: IF/ID instruction; equals BUBBLE_INST when invalid.
- `ifid_pc_next` out WORD_SIZE: PC+1 of the IF/ID instruction.
- `opcode` out 4: `ifid_inst[15:12]`.
- `func_code` out 6: `ifid_inst[5:0]`.
- `fetch_count` out 16: only present with FETCH_COUNT_EN.

## Operation
- **BUBBLE_INST = 16'hF008.** This encoding is R-type with func 8. The control unit decodes it as no reg_write, no memory access, no branch, no jump, and no wwd/halt.
- **Priority when inputs coincide:** reset > redirect > halt > stall.
- **Memory rule:** once `i_readM` rises, `i_readM` and `i_address` stay stable until the cycle `i_ready`=1. Ready may arrive in the same cycle as the request (zero wait).
- **FETCH state:** `i_readM`=1 and `i_address`=pc.
  - `i_ready` and no stall: IF/ID loads `i_data`, valid=1, `ifid_pc_next`=pc+1; pc<=pc+1.
  - `i_ready` and stall: IF/ID holds; `i_data` goes into the skid buffer; go to HOLD.
  - No `i_ready` and no stall: IF/ID becomes a bubble.
  - No `i_ready` and stall: IF/ID holds.
- **HOLD state:** `i_readM`=0. When stall drops, IF/ID loads from the skid buffer, pc<=pc+1, go to FETCH.
- **Redirect:**
  - IF/ID becomes a bubble in every state.
  - From FETCH with `i_ready`=1: the returned data is discarded, pc<=redirect_pc, stay in FETCH.
  - From FETCH with `i_ready`=0: the old request stays asserted; save redirect_pc; go to DROP.
  - From HOLD: the skid buffer is discarded, pc<=redirect_pc, go to FETCH.
- **DROP state:** the old request stays asserted. On `i_ready` the data is discarded, pc<=saved PC, go to FETCH. A second redirect in DROP overwrites the saved PC.
- **Halt:**
  - IF/ID becomes a bubble and the state goes to HALTED.
  - If a request is outstanding, HALTED still waits for `i_ready` with the address held, then discards the data.
  - After that, `i_readM`=0 permanently until reset.
  - Redirect is ignored in HALTED.
- **PC arithmetic:** modulo 2^16; 16'hFFFF+1 wraps to 16'h0000.

## Timing
- **Reset values:** pc=RESET_PC, state=FETCH, `i_readM`=0 in the reset cycle, `ifid_valid`=0, `ifid_inst`=BUBBLE_INST, `ifid_pc_next`=0, skid buffer empty, `fetch_count`=0.
- **First request:** asserted the first cycle `reset_n`=1. Reset mid-request drops the request; the memory side must tolerate abandonment.
- **Latency:** instruction appears in IF/ID one clock after the `i_ready` cycle. Throughput is 1 instruction/cycle with `i_ready` tied high.
- **Combinational paths:** `opcode` and `func_code` are purely combinational from the IF/ID register. Redirect takes effect on `i_address` the cycle after it is asserted.

## Configuration
- **FETCH_COUNT_EN defined:** `fetch_count` increments by 1 on every IF/ID load with valid=1, including loads from the skid buffer. Wraps at 16 bits and resets to 0.
- **Undefined:** the port and counter are absent; behaviour is otherwise identical.

## Structure
- **Shared package `cpu_pkg`:** WORD_SIZE, BUBBLE_INST, the instruction field positions (opcode 15:12, func 5:0), and the fetch state enum (FETCH, HOLD, DROP, HALTED).
- **One sub-module, `ifid_reg`:** the IF/ID register with load/hold/bubble controls. PC logic and the state machine stay in `fetch_unit`.

## Test plan
- **Straight-line fetch:** `i_ready`=1, memory[n]=n|16'h4000, reset released → `i_address` 0,1,2…; `ifid_inst`=16'h4000,16'h4001… one cycle later; `ifid_pc_next`=1,2…
- **Stall with skid:** stall=1 in the same cycle `i_ready` returns 16'h7123 → IF/ID holds; `i_readM`=0 next cycle. When stall drops, `ifid_inst`=16'h7123 and pc advances by exactly 1.
- **Redirect during wait:** `i_ready`=0 for 3 cycles, redirect to 16'h0040 in cycle 1 → address held at the old PC until ready; data discarded; next `i_address`=16'h0040; `ifid_valid`=0 throughout.
- **Redirect with ready same cycle:** returned data is never loaded; next address equals `redirect_pc`.
- **Halt:** halt=1 with stall=1 → `ifid_inst`=16'hF008 and `i_readM`=0 for all following cycles; a later redirect to 16'h0010 is ignored.
- **Counter (FETCH_COUNT_EN):** 5 valid loads, 2 bubbles, 1 flush → `fetch_count`=5. Reset mid-run → 0 in the next cycle.
